deinterleaver_multimode: RTL and testbench
==========================================

# deinterleaver_multimode

Parametrised, double-buffered 802.11a bit deinterleaver covering all four OFDM modulations: BPSK, QPSK, 16-QAM and 64-QAM. It replaces the fixed 192-bit serial deinterleaver in the receive chain between the demapper and the Viterbi decoder. It takes one coded bit per clock in received order and emits one bit per clock in original coded order. Two symbol banks allow a new symbol to be written while the previous one is read out.

## Interface
- MAX_NCBPS, 288: bits per bank. Must be ≥ 288.
- ADDR_W, 9: bank address width. Must satisfy 2^ADDR_W ≥ MAX_NCBPS.
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high; clears all state.
- Input  in  1  received coded bit.
- InputValid  in  1  Input is accepted on a rising edge when InputValid=1 and InputReady=1.
- Mode  in  2  modulation, sampled with the first bit of each symbol:
  - 00 BPSK: N_CBPS=48, s=1
  - 01 QPSK: N_CBPS=96, s=1
  - 10 16-QAM: N_CBPS=192, s=2
  - 11 64-QAM: N_CBPS=288, s=3
- InputReady  out  1  the current write bank is free.
- Output  out  1  deinterleaved bit.
- OutputValid  out  1  Output carries a valid bit.
- OutputFirst  out  1  pulses with the first output bit of each symbol.
- Overflow  out  1  sticky; set when a bit is offered while InputReady=0. Cleared only by Reset.

## Operation
**Write side**
- Write counter wc runs from 0 to N_CBPS−1 and writes into bank wb.
- On the accepted bit with wc=0, the block latches Mode into the bank's mode tag. Mode changes mid-symbol are ignored.
- Each accepted bit is stored at address wc. Bits are stored in received order.
- On the accepted bit with wc=N_CBPS−1: wc←0, bank wb is marked full with its mode tag, and wb toggles.
- InputReady = ~full[wb].
- A bit offered with InputValid=1 and InputReady=0 is discarded, Overflow←1, and wc is unchanged.

**Read side**
- States: IDLE and READ.
- IDLE→READ when full[rb]=1. The block loads N_CBPS and s from the bank's tag and sets k←0.
- In READ, each cycle issues the read address j(k) for bank rb, then k←k+1:
  - i = (N_CBPS/16)·(k mod 16) + floor(k/16)
  - j = s·floor(i/s) + (i + N_CBPS − floor(16·i/N_CBPS)) mod s
- j(k) is computed with integer arithmetic over the full 0..287 range. No address may exceed N_CBPS−1.
- Issuing k=N_CBPS−1:
  - full[rb]←0 on that same edge, so the bank is writable on the next cycle.
  - rb toggles.
  - If full[other bank]=1, the read side stays in READ with k←0 and reloads N_CBPS and s. There is no gap between symbols.
  - Otherwise it goes to IDLE.
- Bank read is registered, so Output, OutputValid and OutputFirst lag the issued address by one edge.
- OutputFirst=1 exactly when the bit for k=0 is presented.

**Simultaneous and boundary events**
- Write completion of bank A and read release of bank B on the same edge: both take effect.
- A bank released on edge t can accept a write on edge t+1.
- Reset mid-operation:
  - Both banks are marked empty; wc, k, wb and rb go to 0; the state goes to IDLE.
  - Any partial symbol and any symbol in flight are discarded.
- Reset values: Output=0, OutputValid=0, OutputFirst=0, Overflow=0, InputReady=1.

## Timing
- Accepting the last input bit of a symbol on edge t sets full on edge t. IDLE→READ and issue of address k=0 happen on t+1. The first bit is presented after edge t+2.
- Latency from the last input bit to the first output bit is 2 cycles.
- Output is one bit per cycle for exactly N_CBPS consecutive cycles, and OutputValid stays high throughout.
- There is no output stall input; downstream must accept one bit per cycle.
- Sustained input of 1 bit/cycle at a constant mode never deasserts InputReady.
- Input of 1 bit/cycle with a switch to a shorter symbol can deassert InputReady. Example: 64-QAM followed by BPSK stalls until the 288-bit read releases its bank.

## Test plan
- BPSK, 48 bits with only received position 3 set -> a single Output=1 at output index 1; OutputFirst high on index 0 only; OutputValid high for exactly 48 cycles.
- 16-QAM, 192 bits with only received position 1 set -> Output=1 only at index 16; first OutputValid exactly 2 cycles after the last accepted bit.
- 64-QAM, 288 bits with only received position 20 set -> Output=1 only at index 1. Repeat with position 0 set -> Output=1 only at index 0.
- Two QPSK symbols back-to-back at 1 bit/cycle, random data -> 192 contiguous OutputValid cycles with OutputFirst at cycles 0 and 96, each symbol matching the software model; InputReady stays 1.
- 64-QAM symbol followed by continuous BPSK symbols with InputValid held high -> InputReady drops until the 64-QAM bank is released. Bits offered during the drop set Overflow=1 and are not written. Later symbols are still deinterleaved correctly.
- Reset asserted mid-READ of a 16-QAM symbol with half of the next symbol written -> OutputValid=0 and InputReady=1 immediately. A fresh BPSK symbol after reset deinterleaves correctly with no stale bits.

Source files
------------

// File: rtl/deinterleaver_multimode.sv
// ---------------------------------------------------------------------------
// deinterleaver_multimode
// Double-buffered 802.11a bit deinterleaver for BPSK/QPSK/16-QAM/64-QAM.
// One coded bit per clock goes in, in received order. Each completed symbol
// is read back in original coded order through a registered bank read.
//
// Ports
//   i_clk       system clock, rising edge
//   i_rst       asynchronous active-high reset
//   i_data      received coded bit
//   i_valid     i_data offered; accepted when o_ready=1
//   i_mode      modulation, sampled with the first bit of each symbol
//                 00 BPSK (48,s=1)  01 QPSK (96,s=1)
//                 10 16-QAM (192,s=2)  11 64-QAM (288,s=3)
//   o_ready     current write bank is free
//   o_data      deinterleaved bit
//   o_valid     o_data carries a valid bit
//   o_first     first output bit of a symbol
//   o_overflow  sticky: a bit was offered while o_ready=0
//
// Read FSM
//   state  | meaning
//   S_IDLE | no full bank; when one appears, go to S_READ and issue k=0
//   S_READ | issue one read address per cycle for bank r_rb
// ---------------------------------------------------------------------------
module deinterleaver_multimode #(
   parameter int MAX_NCBPS = 288,
   parameter int ADDR_W    = 9
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_data,
   input  logic       i_valid,
   input  logic [1:0] i_mode,
   output logic       o_ready,
   output logic       o_data,
   output logic       o_valid,
   output logic       o_first,
   output logic       o_overflow
);

   localparam int AW1 = ADDR_W + 1;

   typedef enum logic {S_IDLE = 1'b0, S_READ = 1'b1} state_t;

   function automatic logic [AW1-1:0] f_ncbps(input logic [1:0] m);
      case (m)
         2'b00:   return AW1'(48);
         2'b01:   return AW1'(96);
         2'b10:   return AW1'(192);
         default: return AW1'(288);
      endcase
   endfunction

   function automatic logic [1:0] f_s(input logic [1:0] m);
      case (m)
         2'b10:   return 2'd2;
         2'b11:   return 2'd3;
         default: return 2'd1;
      endcase
   endfunction

   logic [MAX_NCBPS-1:0] r_mem [2];

   // write side
   logic [ADDR_W-1:0] r_wc;
   logic              r_wb;
   logic [1:0]        r_full;
   logic [1:0]        r_tag [2];
   logic              r_ovf;

   // read side
   state_t            r_state;
   logic [ADDR_W-1:0] r_k;
   logic              r_rb;
   logic [1:0]        r_rd_mode;
   logic [ADDR_W-1:0] r_ra;
   logic              r_rab;
   logic              r_iv;
   logic              r_if;
   logic              r_odata;
   logic              r_ovalid;
   logic              r_ofirst;

   logic              w_accept;
   logic [1:0]        w_wmode;
   logic [AW1-1:0]    w_wn;
   logic              w_wlast;
   logic [1:0]        w_rmode;
   logic [ADDR_W-1:0] w_k;
   logic [AW1-1:0]    w_rn;
   logic [1:0]        w_rs;
   logic              w_rlast;
   logic [ADDR_W-1:0] w_j;

   assign o_ready    = ~r_full[r_wb];
   assign o_data     = r_odata;
   assign o_valid    = r_ovalid;
   assign o_first    = r_ofirst;
   assign o_overflow = r_ovf;

   // The mode tag of the bank being filled is only valid after its first bit,
   // so the first bit uses the live mode input.
   assign w_accept = i_valid & ~r_full[r_wb];
   assign w_wmode  = (r_wc == '0) ? i_mode : r_tag[r_wb];
   assign w_wn     = f_ncbps(w_wmode);
   assign w_wlast  = ({1'b0, r_wc} == (w_wn - AW1'(1)));

   // In S_IDLE the k=0 address is issued on the same edge that enters S_READ,
   // taking the geometry straight from the bank tag.
   assign w_rmode = (r_state == S_IDLE) ? r_tag[r_rb] : r_rd_mode;
   assign w_k     = (r_state == S_IDLE) ? '0 : r_k;
   assign w_rn    = f_ncbps(w_rmode);
   assign w_rs    = f_s(w_rmode);
   assign w_rlast = ({1'b0, w_k} == (w_rn - AW1'(1)));

   // j(k). Since floor(k/16) < N/16, floor(16*i/N) reduces to k mod 16.
   always_comb begin
      logic [AW1-1:0] v_k, v_k16, v_i, v_v, v_r, v_t;
      v_k   = {1'b0, w_k};
      v_k16 = {{(AW1-4){1'b0}}, v_k[3:0]};
      v_i   = (w_rn >> 4) * v_k16 + (v_k >> 4);
      v_v   = v_i + w_rn - v_k16;
      case (w_rs)
         2'd2: begin
            v_r = AW1'(v_i[0]);
            v_t = AW1'(v_v[0]);
         end
         2'd3: begin
            v_r = v_i % AW1'(3);
            v_t = v_v % AW1'(3);
         end
         default: begin
            v_r = '0;
            v_t = '0;
         end
      endcase
      w_j = ADDR_W'(v_i - v_r + v_t);
   end

   always_ff @(posedge i_clk) begin
      if (w_accept) r_mem[r_wb][r_wc] <= i_data;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wc      <= '0;
         r_wb      <= 1'b0;
         r_full    <= '0;
         r_tag[0]  <= '0;
         r_tag[1]  <= '0;
         r_ovf     <= 1'b0;
         r_state   <= S_IDLE;
         r_k       <= '0;
         r_rb      <= 1'b0;
         r_rd_mode <= '0;
         r_ra      <= '0;
         r_rab     <= 1'b0;
         r_iv      <= 1'b0;
         r_if      <= 1'b0;
         r_odata   <= 1'b0;
         r_ovalid  <= 1'b0;
         r_ofirst  <= 1'b0;
      end else begin
         if (i_valid && r_full[r_wb]) r_ovf <= 1'b1;

         if (w_accept) begin
            if (r_wc == '0) r_tag[r_wb] <= i_mode;
            if (w_wlast) begin
               r_wc         <= '0;
               r_full[r_wb] <= 1'b1;
               r_wb         <= ~r_wb;
            end else begin
               r_wc <= r_wc + ADDR_W'(1);
            end
         end

         // Address issue stage; a full read bank means an address goes out.
         r_iv <= 1'b0;
         r_if <= 1'b0;
         if (r_full[r_rb]) begin
            r_ra  <= w_j;
            r_rab <= r_rb;
            r_iv  <= 1'b1;
            r_if  <= (w_k == '0);
         end

         case (r_state)
            S_IDLE: begin
               if (r_full[r_rb]) begin
                  r_state   <= S_READ;
                  r_rd_mode <= r_tag[r_rb];
                  r_k       <= ADDR_W'(1);
               end
            end
            S_READ: begin
               if (w_rlast) begin
                  r_full[r_rb] <= 1'b0;
                  r_rb         <= ~r_rb;
                  r_k          <= '0;
                  if (r_full[~r_rb]) r_rd_mode <= r_tag[~r_rb];
                  else               r_state   <= S_IDLE;
               end else begin
                  r_k <= r_k + ADDR_W'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase

         // Registered bank read.
         r_ovalid <= r_iv;
         r_ofirst <= r_if;
         r_odata  <= r_iv ? r_mem[r_rab][r_ra] : 1'b0;
      end
   end

endmodule

// File: tb/tb_deinterleaver_multimode.sv
module tb_deinterleaver_multimode;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       din = 1'b0;
   logic       vin = 1'b0;
   logic [1:0] mode = 2'b00;
   logic       ready, dout, vout, fout, ovf;

   deinterleaver_multimode #(.MAX_NCBPS(288), .ADDR_W(9)) dut (
      .i_clk(clk), .i_rst(rst), .i_data(din), .i_valid(vin), .i_mode(mode),
      .o_ready(ready), .o_data(dout), .o_valid(vout), .o_first(fout),
      .o_overflow(ovf)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {bit d; bit f;} exp_t;
   exp_t exp_q[$];
   exp_t e;
   bit   cap_d[$];
   bit   cap_f[$];
   int   cap_c[$];

   bit sym[288];
   int sym_cnt = 0;
   int sym_mode = 0;
   int done_cyc = 0;
   int n_rejected = 0;
   int n_acc = 0;

   task automatic check(string nm, int act, int expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
      end
   endtask

   function automatic int ncbps(int m);
      case (m)
         0: return 48;
         1: return 96;
         2: return 192;
         default: return 288;
      endcase
   endfunction

   function automatic int sval(int m);
      if (m == 2) return 2;
      if (m == 3) return 3;
      return 1;
   endfunction

   // Reference: the 802.11a interleaver sends original bit k to position j(k),
   // so original bit k is the received bit at j(k).
   task automatic model_bit(bit b, int m);
      int n, s, i, j;
      if (sym_cnt == 0) sym_mode = m;
      sym[sym_cnt] = b;
      sym_cnt++;
      n = ncbps(sym_mode);
      if (sym_cnt == n) begin
         s = sval(sym_mode);
         for (int k = 0; k < n; k++) begin
            i = (n / 16) * (k % 16) + k / 16;
            j = s * (i / s) + (i + n - (16 * i) / n) % s;
            exp_q.push_back('{d: sym[j], f: (k == 0)});
         end
         sym_cnt  = 0;
         done_cyc = cyc;
      end
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (!rst && vout) begin
         cap_d.push_back(dout);
         cap_f.push_back(fout);
         cap_c.push_back(cyc);
         if (exp_q.size() == 0) begin
            check("unexpected_output", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("sb_data", int'(dout), int'(e.d));
            check("sb_first", int'(fout), int'(e.f));
         end
      end
   end

   task automatic drive(bit b, int m, bit v);
      bit acc;
      din  = b;
      mode = m[1:0];
      vin  = v;
      acc  = v && ready;
      if (v && !ready) n_rejected++;
      @(posedge clk);
      #1;
      if (acc) begin
         n_acc++;
         model_bit(b, m);
      end
      vin = 1'b0;
   endtask

   task automatic wait_drain();
      int c;
      for (c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !vout) break;
      end
      check("drain_timeout", int'(c < 2000), 1);
      check("queue_empty", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic clear_cap();
      cap_d.delete();
      cap_f.delete();
      cap_c.delete();
   endtask

   function automatic int capd(int i);
      return (i < cap_d.size()) ? int'(cap_d[i]) : -1;
   endfunction
   function automatic int capf(int i);
      return (i < cap_f.size()) ? int'(cap_f[i]) : -1;
   endfunction
   function automatic int capc(int i);
      return (i < cap_c.size()) ? cap_c[i] : -1000;
   endfunction
   function automatic int sum_d();
      int s = 0;
      foreach (cap_d[i]) s += int'(cap_d[i]);
      return s;
   endfunction
   function automatic int sum_f();
      int s = 0;
      foreach (cap_f[i]) s += int'(cap_f[i]);
      return s;
   endfunction

   // Single-one directed symbol: returns nothing, checks index of the one.
   task automatic single_one(int m, int pos, int idx, string nm);
      int n;
      n = ncbps(m);
      clear_cap();
      for (int p = 0; p < n; p++) drive(p == pos, m, 1'b1);
      wait_drain();
      check({nm, "_count"}, cap_d.size(), n);
      check({nm, "_ones"}, sum_d(), 1);
      check({nm, "_bit"}, capd(idx), 1);
      check({nm, "_firsts"}, sum_f(), 1);
      check({nm, "_first0"}, capf(0), 1);
      check({nm, "_contig"}, capc(n - 1) - capc(0), n - 1);
      check({nm, "_latency"}, capc(0) - done_cyc, 2);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int start;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", int'(vout), 0);
      check("rst_first", int'(fout), 0);
      check("rst_data", int'(dout), 0);
      check("rst_ovf", int'(ovf), 0);
      check("rst_ready", int'(ready), 1);
      rst = 1'b0;
      @(posedge clk);
      #1;

      single_one(0, 3, 1, "bpsk");
      single_one(2, 1, 16, "qam16");
      single_one(3, 20, 1, "qam64_p20");
      single_one(3, 0, 0, "qam64_p0");

      // Two QPSK symbols back to back, random data.
      clear_cap();
      n_rejected = 0;
      for (int p = 0; p < 192; p++) drive(1'($urandom), 1, 1'b1);
      wait_drain();
      check("qpsk_count", cap_d.size(), 192);
      check("qpsk_first0", capf(0), 1);
      check("qpsk_first96", capf(96), 1);
      check("qpsk_firsts", sum_f(), 2);
      check("qpsk_contig", capc(191) - capc(0), 191);
      check("qpsk_no_stall", n_rejected, 0);
      check("qpsk_ovf", int'(ovf), 0);

      // 64-QAM then continuous BPSK with valid held high.
      clear_cap();
      n_rejected = 0;
      for (int p = 0; p < 288; p++) drive(1'($urandom), 3, 1'b1);
      start = n_acc;
      for (int c = 0; c < 3000 && (n_acc - start) < 288; c++)
         drive(1'($urandom), 0, 1'b1);
      check("stall_accepted", n_acc - start, 288);
      check("stall_seen", int'(n_rejected > 0), 1);
      check("stall_ovf", int'(ovf), 1);
      wait_drain();
      check("stall_count", cap_d.size(), 576);
      check("stall_firsts", sum_f(), 7);

      // Reset mid-read of 16-QAM with half of the next symbol written.
      for (int p = 0; p < 192 + 96; p++) drive(1'($urandom), 2, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("mrst_valid", int'(vout), 0);
      check("mrst_ready", int'(ready), 1);
      check("mrst_ovf", int'(ovf), 0);
      check("mrst_data", int'(dout), 0);
      exp_q.delete();
      sym_cnt = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      clear_cap();
      for (int p = 0; p < 48; p++) drive(1'($urandom), 0, 1'b1);
      wait_drain();
      check("post_rst_count", cap_d.size(), 48);
      check("post_rst_firsts", sum_f(), 1);
      check("post_rst_latency", capc(0) - done_cyc, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
